// File: rtl/pipe_sel_mux_if.sv
// -----------------------------------------------------------------------------
// pipe_sel_mux_if
// Bundles the channel bus, the select/scan controls and both valid/ready
// handshakes of the pipelined selection mux.
//
// Signals:
//   in_data   packed channel words, channel k at [k*WIDTH +: WIDTH]
//   in_sel    channel select (used when scan_en=0)
//   in_valid  input beat valid
//   in_ready  mux can accept a beat this cycle
//   scan_en   1 = channel comes from the internal round-robin pointer
//   scan_clr  synchronous clear of the round-robin pointer
//   out_data  selected word (0 when out_err)
//   out_ch    channel index that produced out_data
//   out_err   selected index was >= NUM_CH
//   out_valid output beat valid
//   out_ready downstream accepts the beat
//
// Modports: master = producer/consumer side, slave = the mux itself.
// -----------------------------------------------------------------------------
interface pipe_sel_mux_if #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 32,
   parameter int SEL_W  = 5
);
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]        in_sel;
   logic                    in_valid;
   logic                    in_ready;
   logic                    scan_en;
   logic                    scan_clr;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_ch;
   logic                    out_err;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_data, in_sel, in_valid, scan_en, scan_clr, out_ready,
      input  in_ready, out_data, out_ch, out_err, out_valid
   );

   modport slave (
      input  in_data, in_sel, in_valid, scan_en, scan_clr, out_ready,
      output in_ready, out_data, out_ch, out_err, out_valid
   );
endinterface

// File: rtl/pipe_sel_mux.sv
// -----------------------------------------------------------------------------
// pipe_sel_mux
// Two-level pipelined N:1 word multiplexer with valid/ready handshake.
// Level 1 picks one word out of every GROUP-channel group using the low select
// bits; level 2 picks one group word using the high select bits. Each level is
// registered, giving 2-cycle latency and 1 beat/cycle throughput.
// An auto-scan mode takes the channel from an internal round-robin pointer,
// and selects >= NUM_CH are flagged with out_err and a zero data word.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pipe_sel_mux_if.slave (channel bus, controls, both handshakes)
//
// Parameters: WIDTH bits per word, NUM_CH channels (multiple of GROUP,
// at most 2**SEL_W), SEL_W select width, GROUP channels per first-level
// group (power of two, at least 2, fewer than 2**SEL_W).
// -----------------------------------------------------------------------------
module pipe_sel_mux #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 32,
   parameter int SEL_W  = 5,
   parameter int GROUP  = 16
) (
   input logic           clk,
   input logic           rst,
   pipe_sel_mux_if.slave bus
);

   localparam int NGRP = NUM_CH / GROUP;
   localparam int LO_W = $clog2(GROUP);
   localparam int SW1  = SEL_W + 1;
   // one extra bit so NUM_CH == 2**SEL_W is representable
   localparam logic [SEL_W:0]   NUM_CH_X = SW1'(NUM_CH);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

   logic                    s1_adv;
   logic                    s2_adv;
   logic                    accept;
   logic [SEL_W-1:0]        scan_ptr;

   logic [SEL_W-1:0]        ch_p0;
   logic                    err_p0;
   logic [NGRP*WIDTH-1:0]   grp_p0;

   logic                    vld_p1;
   logic [SEL_W-1:0]        ch_p1;
   logic                    err_p1;
   logic [NGRP*WIDTH-1:0]   grp_p1;
   logic [WIDTH-1:0]        word_p1;

   logic                    vld_p2;
   logic [WIDTH-1:0]        data_p2;
   logic [SEL_W-1:0]        ch_p2;
   logic                    err_p2;

   // Stage 2 can take a new beat when it is empty or being drained; stage 1
   // when it is empty or moving into stage 2. in_ready depends on out_ready
   // and register state only, never on in_valid.
   assign s2_adv      = ~vld_p2 | bus.out_ready;
   assign s1_adv      = ~vld_p1 | s2_adv;
   assign bus.in_ready = s1_adv;
   assign accept      = bus.in_valid & s1_adv;

   // ---- stage 0: effective channel and first-level group selection ----
   assign ch_p0  = bus.scan_en ? scan_ptr : bus.in_sel;
   assign err_p0 = {1'b0, ch_p0} >= NUM_CH_X;

   // A right shift of the group slice by (low select * WIDTH) followed by a
   // truncating cast is a GROUP:1 word mux without variable-index selects.
   for (genvar g = 0; g < NGRP; g++) begin : g_grp
      assign grp_p0[g*WIDTH +: WIDTH] =
         WIDTH'(bus.in_data[g*GROUP*WIDTH +: GROUP*WIDTH] >> (WIDTH * int'(ch_p0[LO_W-1:0])));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_ptr <= '0;
      end else if (bus.scan_clr) begin
         // clear wins; a beat accepted this cycle already used the old value
         scan_ptr <= '0;
      end else if (accept && bus.scan_en) begin
         scan_ptr <= (scan_ptr == LAST_CH) ? '0 : scan_ptr + SEL_W'(1);
      end
   end

   // ---- stage 1: registered group words, channel tag and range flag ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else if (s1_adv) begin
         vld_p1 <= accept;
      end
   end

   // payload needs no reset: it is only consumed while vld_p1 is set
   always_ff @(posedge clk) begin
      if (accept) begin
         grp_p1 <= grp_p0;
         ch_p1  <= ch_p0;
         err_p1 <= err_p0;
      end
   end

   // Group indices past the last group shift everything out to zero; err_p1
   // covers those cases anyway and also blanks in-range groups of bad selects.
   assign word_p1 = err_p1 ? '0 : WIDTH'(grp_p1 >> (WIDTH * int'(ch_p1[SEL_W-1:LO_W])));

   // ---- stage 2: output registers ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         data_p2 <= '0;
         ch_p2   <= '0;
         err_p2  <= 1'b0;
      end else if (s2_adv) begin
         vld_p2 <= vld_p1;
         // a bubble clears valid but leaves the last payload visible
         if (vld_p1) begin
            data_p2 <= word_p1;
            ch_p2   <= ch_p1;
            err_p2  <= err_p1;
         end
      end
   end

   assign bus.out_valid = vld_p2;
   assign bus.out_data  = data_p2;
   assign bus.out_ch    = ch_p2;
   assign bus.out_err   = err_p2;

endmodule

// File: tb/tb_pipe_sel_mux.sv
// -----------------------------------------------------------------------------
// tb_pipe_sel_mux
// Runs two instances side by side on identical stimulus: a 32-channel mux
// with 16-channel groups and a 24-channel mux with 8-channel groups. Each is
// compared against a transaction-level model: a FIFO of accepted beats whose
// contents come straight from the selection rules, plus an in-flight count
// that gives the expected in_ready and out_valid.
// -----------------------------------------------------------------------------
module tb_pipe_sel_mux;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   pipe_sel_mux_if #(.WIDTH(32), .NUM_CH(32), .SEL_W(5)) ifa ();
   pipe_sel_mux_if #(.WIDTH(32), .NUM_CH(24), .SEL_W(5)) ifb ();

   pipe_sel_mux #(.WIDTH(32), .NUM_CH(32), .SEL_W(5), .GROUP(16)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   pipe_sel_mux #(.WIDTH(32), .NUM_CH(24), .SEL_W(5), .GROUP(8)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   logic [31:0] o_data [2];
   logic [4:0]  o_ch   [2];
   logic        o_err  [2];
   logic        o_vld  [2];
   logic        o_rdy  [2];

   assign o_data[0] = ifa.out_data;   assign o_data[1] = ifb.out_data;
   assign o_ch[0]   = ifa.out_ch;     assign o_ch[1]   = ifb.out_ch;
   assign o_err[0]  = ifa.out_err;    assign o_err[1]  = ifb.out_err;
   assign o_vld[0]  = ifa.out_valid;  assign o_vld[1]  = ifb.out_valid;
   assign o_rdy[0]  = ifa.in_ready;   assign o_rdy[1]  = ifb.in_ready;

   int n_tests;
   int n_fail;

   // channel contents, shared by both instances (dut_b sees the first 24)
   logic [31:0] mem [32];

   // reference model state per instance
   int          nch      [2];
   int          ptr      [2];
   int          inflight [2];
   int          wr       [2];
   int          rd       [2];
   bit          acc_last [2];
   logic [31:0] q_data   [2][64];
   logic [4:0]  q_ch     [2][64];
   bit          q_err    [2][64];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         ptr[d]      = 0;
         inflight[d] = 0;
         wr[d]       = 0;
         rd[d]       = 0;
         acc_last[d] = 1'b0;
      end
   endtask

   task automatic drive(input bit v, input logic [4:0] sel, input bit se, input bit sc,
                        input bit ordy);
      ifa.in_valid  = v;    ifb.in_valid  = v;
      ifa.in_sel    = sel;  ifb.in_sel    = sel;
      ifa.scan_en   = se;   ifb.scan_en   = se;
      ifa.scan_clr  = sc;   ifb.scan_clr  = sc;
      ifa.out_ready = ordy; ifb.out_ready = ordy;
      for (int k = 0; k < 32; k++) begin
         ifa.in_data[k*32 +: 32] = mem[k];
         if (k < 24) ifb.in_data[k*32 +: 32] = mem[k];
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid_a"}, 64'(o_vld[0]), 64'd0);
      chk({tag, "_out_data_a"},  64'(o_data[0]), 64'd0);
      chk({tag, "_out_ch_a"},    64'(o_ch[0]), 64'd0);
      chk({tag, "_out_err_a"},   64'(o_err[0]), 64'd0);
      chk({tag, "_in_ready_a"},  64'(o_rdy[0]), 64'd1);
      chk({tag, "_out_valid_b"}, 64'(o_vld[1]), 64'd0);
      chk({tag, "_out_data_b"},  64'(o_data[1]), 64'd0);
      chk({tag, "_in_ready_b"},  64'(o_rdy[1]), 64'd1);
   endtask

   // One clock cycle: drive at the falling edge, check the settled outputs,
   // then advance the model by what the coming rising edge will do.
   task automatic cycle(input bit v, input logic [4:0] sel, input bit se, input bit sc,
                        input bit ordy);
      logic [4:0] ch;
      bit         err;
      bit         er;
      bit         eo;
      string      sfx;
      @(negedge clk);
      drive(v, sel, se, sc, ordy);
      #1;
      for (int d = 0; d < 2; d++) begin
         sfx = (d == 0) ? "_a" : "_b";
         // only two beats fit; the mux is blocked when both are held and stalled
         er = !(inflight[d] == 2 && !ordy);
         // a lone beat accepted at the last edge is still one stage short
         eo = (inflight[d] == 2) || (inflight[d] == 1 && !acc_last[d]);
         chk({"in_ready", sfx},  64'(o_rdy[d]), 64'(er));
         chk({"out_valid", sfx}, 64'(o_vld[d]), 64'(eo));
         acc_last[d] = 1'b0;
         if (eo && ordy) begin
            chk({"out_data", sfx}, 64'(o_data[d]), 64'(q_data[d][rd[d]]));
            chk({"out_ch", sfx},   64'(o_ch[d]),   64'(q_ch[d][rd[d]]));
            chk({"out_err", sfx},  64'(o_err[d]),  64'(q_err[d][rd[d]]));
            rd[d] = (rd[d] + 1) % 64;
            inflight[d]--;
         end
         if (v && er) begin
            ch  = se ? 5'(ptr[d]) : sel;
            err = int'(ch) >= nch[d];
            q_data[d][wr[d]] = err ? 32'h0 : mem[ch];
            q_ch[d][wr[d]]   = ch;
            q_err[d][wr[d]]  = err;
            wr[d] = (wr[d] + 1) % 64;
            inflight[d]++;
            acc_last[d] = 1'b1;
            if (se) ptr[d] = (ptr[d] + 1) % nch[d];
         end
         if (sc) ptr[d] = 0;
      end
   endtask

   task automatic drain();
      repeat (4) cycle(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      int k;
      n_tests = 0;
      n_fail  = 0;
      nch[0]  = 32;
      nch[1]  = 24;
      for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
      model_reset();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

      // reset state, then release between clock edges
      repeat (2) @(negedge clk);
      #1;
      chk_reset_state("reset");
      #1 rst = 1'b0;

      // direct selects across both groups, no stall
      cycle(1'b1, 5'd0,  1'b0, 1'b0, 1'b1);
      cycle(1'b1, 5'd15, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 5'd16, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 5'd31, 1'b0, 1'b0, 1'b1);
      drain();

      // back-pressure: six beats, out_ready pattern 1,0,0 repeating
      k = 0;
      for (int i = 0; i < 100 && k < 6; i++) begin
         cycle(1'b1, 5'(k), 1'b0, 1'b0, (i % 3) == 0);
         if (acc_last[0]) k++;
      end
      chk("bp_beats_accepted", 64'(k), 64'd6);
      repeat (3) cycle(1'b0, 5'd0, 1'b0, 1'b0, (k % 2) == 0);
      drain();

      // auto-scan across the wrap point
      cycle(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      repeat (34) cycle(1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
      drain();

      // scan_clr together with an accept at pointer 7
      cycle(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      repeat (7) cycle(1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 5'd0, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
      drain();

      // out-of-range select on the 24-channel instance, then a valid one
      cycle(1'b1, 5'd26, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 5'd23, 1'b0, 1'b0, 1'b1);
      drain();

      // randomized traffic, data changing under the pipe
      for (int i = 0; i < 600; i++) begin
         mem[$urandom_range(0, 31)] = $urandom;
         cycle(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      end
      drain();

      // asynchronous reset with both stages full
      cycle(1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk_reset_state("async_rst");
      @(negedge clk);
      #1;
      chk_reset_state("rst_held");
      #2 rst = 1'b0;
      model_reset();
      cycle(1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
